// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Multi-cycle controller for the 8-bit A/B-register add/subtract ALU. It accepts one
// command at a time over a valid/ready handshake and requests the shared bus. It then
// steps through the operand loads, an optional adder settle window, and the result
// write with flag capture. The block drives no bus data itself. It only decides which
// source drives the bus and which register loads from it.
//
// Parameters
//   SETTLE_CYCLES  idle cycles between load of B and the result write (0..15)
//   TIMEOUT        cycles spent waiting in REQ without a grant before giving up (1..255)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_op      0=ADD, 1=SUB, 2=CMP (subtract, flags only), 3=ACC (keep A, load B, add)
//   cmd_ready   sequencer idle; command taken when cmd_valid && cmd_ready
//   bus_req     request ownership of the shared bus
//   bus_gnt     bus ownership granted by the arbiter
//   opa_oe      operand-A source drives the bus
//   opb_oe      operand-B source drives the bus
//   load_A      ALU register A loads from the bus at this edge
//   load_B      ALU register B loads from the bus at this edge
//   write_ALU   ALU drives its result onto the bus
//   subtract    ALU mode select, 1 = A - B
//   res_load    destination register loads the ALU result at this edge
//   carry       ALU carry output (combinational)
//   zero        ALU zero output (combinational)
//   carry_flag  latched carry flag
//   zero_flag   latched zero flag
//   done        one-cycle pulse during the EXEC cycle
//   err         one-cycle registered pulse after a timeout or grant-loss abort

module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       opa_oe,
    output logic       opb_oe,
    output logic       load_A,
    output logic       load_B,
    output logic       write_ALU,
    output logic       subtract,
    output logic       res_load,
    input  logic       carry,
    input  logic       zero,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpCmp = 2'd2;
    localparam logic [1:0] OpAcc = 2'd3;

    // Terminal counts. The settle terminal is only consulted when SETTLE_CYCLES > 0.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [7:0] SettleLast  = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLdA,
        StLdB,
        StSettle,
        StExec
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       carry_flag_q, carry_flag_d;
    logic       zero_flag_q, zero_flag_d;
    logic       err_q, err_d;
    logic       abort;

    // State register. Reset wins over everything, including an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OpAdd;
            cnt_q        <= 8'd0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            carry_flag_q <= carry_flag_d;
            zero_flag_q  <= zero_flag_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic. Once the bus is granted, losing it at any later step abandons the
    // operation. The flags are left untouched on every abort path.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        carry_flag_d = carry_flag_q;
        zero_flag_d  = zero_flag_q;
        abort        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    cnt_d   = 8'd0;
                    state_d = StReq;
                end
            end

            StReq: begin
                if (bus_gnt) begin
                    // ACC reuses the A register contents, so the A load is skipped.
                    state_d = (op_q == OpAcc) ? StLdB : StLdA;
                end else if (cnt_q == TimeoutLast) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StLdA: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StLdB;
                end
            end

            StLdB: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (SETTLE_CYCLES > 0) begin
                    cnt_d   = 8'd0;
                    state_d = StSettle;
                end else begin
                    state_d = StExec;
                end
            end

            StSettle: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StExec: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    carry_flag_d = carry;
                    zero_flag_d  = zero;
                    state_d      = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        err_d = abort;
    end

    // Moore outputs decoded from state and the latched op. The register load strobes are
    // additionally gated with the grant so an aborting cycle cannot corrupt any register.
    // The three bus drivers are decoded from three different states, so at most one of them
    // is active in any cycle.
    always_comb begin
        cmd_ready = 1'b0;
        bus_req   = 1'b0;
        opa_oe    = 1'b0;
        opb_oe    = 1'b0;
        load_A    = 1'b0;
        load_B    = 1'b0;
        write_ALU = 1'b0;
        subtract  = 1'b0;
        res_load  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
            end

            StReq: begin
                bus_req = 1'b1;
            end

            StLdA: begin
                bus_req = 1'b1;
                opa_oe  = 1'b1;
                load_A  = bus_gnt;
            end

            StLdB: begin
                bus_req = 1'b1;
                opb_oe  = 1'b1;
                load_B  = bus_gnt;
            end

            StSettle: begin
                bus_req  = 1'b1;
                subtract = (op_q == OpSub) || (op_q == OpCmp);
            end

            StExec: begin
                bus_req   = 1'b1;
                write_ALU = 1'b1;
                done      = 1'b1;
                subtract  = (op_q == OpSub) || (op_q == OpCmp);
                // CMP only updates the flags and never writes a result.
                res_load  = (op_q != OpCmp) && bus_gnt;
            end

            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign carry_flag = carry_flag_q;
    assign zero_flag  = zero_flag_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. Two instances share the stimulus:
//   dut_a: SETTLE_CYCLES=0, TIMEOUT=4
//   dut_b: SETTLE_CYCLES=2, TIMEOUT=15
// Each scenario checks one instance cycle by cycle against a hand-computed output vector.
// Vector bit order is
//   cmd_ready bus_req opa_oe opb_oe load_A load_B write_ALU subtract res_load done err cf zf.

module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       bus_gnt;
    logic       carry;
    logic       zero;

    logic a_cmd_ready, a_bus_req, a_opa_oe, a_opb_oe, a_load_A, a_load_B, a_write_ALU;
    logic a_subtract, a_res_load, a_carry_flag, a_zero_flag, a_done, a_err;
    logic b_cmd_ready, b_bus_req, b_opa_oe, b_opb_oe, b_load_A, b_load_B, b_write_ALU;
    logic b_subtract, b_res_load, b_carry_flag, b_zero_flag, b_done, b_err;

    int vectors;
    int miscompares;

    alu_sequencer #(
        .SETTLE_CYCLES(0),
        .TIMEOUT      (4)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (a_cmd_ready),
        .bus_req    (a_bus_req),
        .bus_gnt    (bus_gnt),
        .opa_oe     (a_opa_oe),
        .opb_oe     (a_opb_oe),
        .load_A     (a_load_A),
        .load_B     (a_load_B),
        .write_ALU  (a_write_ALU),
        .subtract   (a_subtract),
        .res_load   (a_res_load),
        .carry      (carry),
        .zero       (zero),
        .carry_flag (a_carry_flag),
        .zero_flag  (a_zero_flag),
        .done       (a_done),
        .err        (a_err)
    );

    alu_sequencer #(
        .SETTLE_CYCLES(2),
        .TIMEOUT      (15)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (b_cmd_ready),
        .bus_req    (b_bus_req),
        .bus_gnt    (bus_gnt),
        .opa_oe     (b_opa_oe),
        .opb_oe     (b_opb_oe),
        .load_A     (b_load_A),
        .load_B     (b_load_B),
        .write_ALU  (b_write_ALU),
        .subtract   (b_subtract),
        .res_load   (b_res_load),
        .carry      (carry),
        .zero       (zero),
        .carry_flag (b_carry_flag),
        .zero_flag  (b_zero_flag),
        .done       (b_done),
        .err        (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] outs_a();
        return {a_cmd_ready, a_bus_req, a_opa_oe, a_opb_oe, a_load_A, a_load_B, a_write_ALU,
                a_subtract, a_res_load, a_done, a_err, a_carry_flag, a_zero_flag};
    endfunction

    function automatic logic [12:0] outs_b();
        return {b_cmd_ready, b_bus_req, b_opa_oe, b_opb_oe, b_load_A, b_load_B, b_write_ALU,
                b_subtract, b_res_load, b_done, b_err, b_carry_flag, b_zero_flag};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        logic [12:0] want;
        want = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        vectors++;
        if (outs_a() !== want) begin
            $display("FAIL reset_a_in: got %b want %b", outs_a(), want);
            miscompares++;
        end
        vectors++;
        if (outs_b() !== want) begin
            $display("FAIL reset_b_in: got %b want %b", outs_b(), want);
            miscompares++;
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs_a() !== want) begin
            $display("FAIL reset_a_after: got %b want %b", outs_a(), want);
            miscompares++;
        end
        vectors++;
        if (outs_b() !== want) begin
            $display("FAIL reset_b_after: got %b want %b", outs_b(), want);
            miscompares++;
        end
        next_cycle();
    endtask

    task automatic test_add();
        logic [12:0] want [6];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
        want[2] = 13'b0_1_1_0_1_0_0_0_0_0_0_0_0;
        want[3] = 13'b0_1_0_1_0_1_0_0_0_0_0_0_0;
        want[4] = 13'b0_1_0_0_0_0_1_0_1_1_0_0_0;
        want[5] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        bus_gnt = 1'b1;
        carry   = 1'b0;
        zero    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = (i == 0);
            cmd_op    = 2'd0;
            @(negedge clk);
            vectors++;
            if (outs_a() !== want[i]) begin
                $display("FAIL add cyc%0d: got %b want %b", i, outs_a(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        idle(3);
    endtask

    task automatic test_sub_settle();
        logic [12:0] want [8];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
        want[2] = 13'b0_1_1_0_1_0_0_0_0_0_0_0_0;
        want[3] = 13'b0_1_0_1_0_1_0_0_0_0_0_0_0;
        want[4] = 13'b0_1_0_0_0_0_0_1_0_0_0_0_0;
        want[5] = 13'b0_1_0_0_0_0_0_1_0_0_0_0_0;
        want[6] = 13'b0_1_0_0_0_0_1_1_1_1_0_0_0;
        want[7] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_1;
        bus_gnt = 1'b1;
        carry   = 1'b1;
        zero    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = (i == 0);
            cmd_op    = 2'd1;
            @(negedge clk);
            vectors++;
            if (outs_b() !== want[i]) begin
                $display("FAIL sub_settle cyc%0d: got %b want %b", i, outs_b(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [12:0] want [10];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_1;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_1;
        want[2] = 13'b0_1_1_0_1_0_0_0_0_0_0_1_1;
        want[3] = 13'b0_1_0_1_0_1_0_0_0_0_0_1_1;
        want[4] = 13'b0_1_0_0_0_0_1_1_0_1_0_1_1;
        want[5] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_1;
        want[6] = 13'b0_1_0_0_0_0_0_0_0_0_0_0_1;
        want[7] = 13'b0_1_0_1_0_1_0_0_0_0_0_0_1;
        want[8] = 13'b0_1_0_0_0_0_1_0_1_1_0_0_1;
        want[9] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        bus_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i == 0) || (i == 5);
            cmd_op    = (i < 5) ? 2'd2 : 2'd3;
            carry     = (i >= 5);
            zero      = (i < 5);
            @(negedge clk);
            vectors++;
            if (outs_a() !== want[i]) begin
                $display("FAIL cmp_acc cyc%0d: got %b want %b", i, outs_a(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_timeout();
        logic [12:0] want [7];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[2] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[3] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[4] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[5] = 13'b1_0_0_0_0_0_0_0_0_0_1_1_0;
        want[6] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        bus_gnt = 1'b0;
        carry   = 1'b1;
        zero    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = (i == 0);
            cmd_op    = 2'd0;
            @(negedge clk);
            vectors++;
            if (outs_a() !== want[i]) begin
                $display("FAIL timeout cyc%0d: got %b want %b", i, outs_a(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        idle(12);
        bus_gnt = 1'b1;
        idle(1);
    endtask

    task automatic test_grant_loss();
        logic [12:0] want [6];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[2] = 13'b0_1_1_0_1_0_0_0_0_0_0_1_0;
        want[3] = 13'b0_1_0_1_0_0_0_0_0_0_0_1_0;
        want[4] = 13'b1_0_0_0_0_0_0_0_0_0_1_1_0;
        want[5] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        carry = 1'b1;
        zero  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = (i == 0);
            cmd_op    = 2'd0;
            bus_gnt   = (i < 3);
            @(negedge clk);
            vectors++;
            if (outs_a() !== want[i]) begin
                $display("FAIL gnt_loss cyc%0d: got %b want %b", i, outs_a(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        bus_gnt = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_mid_op();
        logic [12:0] want [7];
        want[0] = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
        want[1] = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;
        want[2] = 13'b0_1_1_0_1_0_0_0_0_0_0_1_0;
        want[3] = 13'b0_1_0_1_0_1_0_0_0_0_0_1_0;
        want[4] = 13'b0_1_0_0_0_0_0_1_0_0_0_1_0;
        want[5] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        want[6] = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
        bus_gnt = 1'b1;
        carry   = 1'b1;
        zero    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = (i == 0);
            cmd_op    = 2'd1;
            rst       = (i == 4);
            @(negedge clk);
            vectors++;
            if (outs_b() !== want[i]) begin
                $display("FAIL rst_settle cyc%0d: got %b want %b", i, outs_b(), want[i]);
                miscompares++;
            end
            next_cycle();
        end
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        bus_gnt     = 1'b0;
        carry       = 1'b0;
        zero        = 1'b0;

        test_reset();
        test_add();
        test_sub_settle();
        test_back_to_back();
        test_timeout();
        test_grant_loss();
        test_reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
